// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Package : md_pkg
// Brief   : Op encodings, FSM state type and op-decode helpers shared by the
//           multiply/divide unit and its iterative divider.
// Rev     : 1.0 - initial release
// ============================================================================
package md_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'b000;
  localparam md_op_t MD_MULTU = 3'b001;
  localparam md_op_t MD_DIV   = 3'b010;
  localparam md_op_t MD_DIVU  = 3'b011;
  localparam md_op_t MD_MADD  = 3'b100;
  localparam md_op_t MD_MADDU = 3'b101;
  localparam md_op_t MD_MSUB  = 3'b110;
  localparam md_op_t MD_MSUBU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // DIV/DIVU go to the bit-serial divider; everything else is multiply-class
  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Two's-complement interpretation of the operands
  function automatic logic is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  // Result is folded into the current {HI,LO} rather than replacing it
  function automatic logic is_acc(input md_op_t op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  // Accumulate direction is subtract
  function automatic logic is_sub(input md_op_t op);
    return (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_div_iter.sv
`default_nettype none
// ============================================================================
// Module : md_div_iter
// Brief  : Restoring bit-serial divider on unsigned magnitudes. One quotient
//          bit per clock; WIDTH iterations after go. Results hold until the
//          next go or cancel.
// Rev    : 1.0 - initial release
// ============================================================================
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             run_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;   // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   rem_shift;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // When it fits the true difference is below the divisor, so a WIDTH-bit
  // subtraction is exact.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    qbit      = (rem_shift >= {1'b0, dvs_q});
    rem_d     = qbit ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
  end

  // Load on go, iterate while running, flag valid after the final step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else if (cancel_i) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (go_i) begin
      run_q   <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      dvs_q   <= divisor_i;
      quo_q   <= dividend_i;
      rem_q   <= '0;
    end else if (run_q) begin
      quo_q <= {quo_q[WIDTH-2:0], qbit};
      rem_q <= rem_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        run_q   <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign last_o  = run_q && (cnt_q == CNT_LAST);
  assign valid_o = valid_q;
  assign quot_o  = quo_q;
  assign rem_o   = rem_q;

endmodule

`default_nettype wire

// File: rtl/md_unit_param.sv
`default_nettype none
// ============================================================================
// Module : md_unit_param
// Brief  : Multi-cycle multiply / multiply-accumulate / divide unit owning the
//          HI/LO pair. Fixed-latency multiply, bit-serial divide with a sign
//          fixup cycle, done pulse and cancel for pipeline flush.
// Rev    : 1.0 - initial release
// ============================================================================
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               DW       = 2 * WIDTH;
  localparam int               CNT_W    = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] mul_cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  md_op_t           op_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             busy_c;
  logic             launch;
  logic             div_go;
  logic             mul_commit;
  logic             div_commit;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             div_last, div_valid;
  logic [WIDTH-1:0] div_quot, div_rem;

  logic [DW-1:0]    mul_a_ext, mul_b_ext, product, acc, mul_res;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] div_hi, div_lo;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; cancel returns any active state to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !cancel) state_d = is_div(op) ? ST_DIV : ST_MUL;
      ST_MUL:  if (cancel || (mul_cnt_q == MUL_LAST)) state_d = ST_IDLE;
      ST_DIV:  if (cancel) state_d = ST_IDLE;
               else if (div_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy, launch and commit strobes
  always_comb begin
    busy_c     = (state_q != ST_IDLE);
    launch     = (state_q == ST_IDLE) && start && !cancel;
    div_go     = launch && is_div(op);
    mul_commit = (state_q == ST_MUL) && !cancel && (mul_cnt_q == MUL_LAST);
    div_commit = (state_q == ST_FIX) && !cancel && div_valid;
  end

  // Operand capture at launch and multiply busy-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= MD_MULT;
      mul_cnt_q <= '0;
    end else if (launch) begin
      a_q       <= a;
      b_q       <= b;
      op_q      <= op;
      mul_cnt_q <= '0;
    end else if (state_q == ST_MUL) begin
      mul_cnt_q <= mul_cnt_q + CNT_W'(1);
    end
  end

  // Unsigned magnitudes handed to the divider at launch
  always_comb begin
    dvd_mag = a;
    dvs_mag = b;
    if (is_signed(op)) begin
      if (a[WIDTH-1]) dvd_mag = -a;
      if (b[WIDTH-1]) dvs_mag = -b;
    end
  end

  md_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .go_i       (div_go),
    .cancel_i   (cancel),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .last_o     (div_last),
    .valid_o    (div_valid),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // Product from captured operands; accumulate against HI/LO as they stand
  // at completion so an mthi/mtlo issued alongside the launch is included
  always_comb begin
    mul_a_ext = is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b_ext = is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product   = mul_a_ext * mul_b_ext;
    acc       = {hi_q, lo_q};
    if (!is_acc(op_q))     mul_res = product;
    else if (is_sub(op_q)) mul_res = acc - product;
    else                   mul_res = acc + product;
  end

  // Divide sign fixup; divide-by-zero bypasses the magnitudes entirely.
  // min/-1 needs no special case: the negated magnitude wraps back to min.
  always_comb begin
    q_neg = is_signed(op_q) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
    r_neg = is_signed(op_q) && a_q[WIDTH-1];
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else begin
      div_lo = q_neg ? -div_quot : div_quot;
      div_hi = r_neg ? -div_rem  : div_rem;
    end
  end

  // HI/LO: op results at completion, direct writes only while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mul_commit) begin
      {hi_q, lo_q} <= mul_res;
    end else if (div_commit) begin
      hi_q <= div_hi;
      lo_q <= div_lo;
    end else if (!busy_c) begin
      if (mthi) hi_q <= a;
      if (mtlo) lo_q <= a;
    end
  end

  // Done pulse coincides with the edge that writes the result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= mul_commit || div_commit;
  end

  assign busy = busy_c;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire
